pkt_disassembler: RTL and testbench
===================================

# pkt_disassembler

Receive-side counterpart of the event-to-packet assembler. It accepts 72-bit SpiNNaker packets from the link side, checks their parity, filters out non-multicast packets, and emits the routing key as a 32-bit event word. If the packet carries a payload, the payload follows as a second event word. Dropped packets are counted and the counts are visible to the register bank.

## Interface
Parameters:
- PACKET_BITS, 72, packet width; the block supports 72 only ({payload[31:0], key[31:0], header[7:0]}).
- CNT_BITS, 16, width of each saturating error counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- pkt_data_in  in  PACKET_BITS  incoming packet.
- pkt_vld_in  in  1  packet valid.
- pkt_rdy_out  out  1  packet ready; combinational (see Operation).
- evt_data_out  out  32  event word: key, or payload.
- evt_vld_out  out  1  event valid; registered.
- evt_rdy_in  in  1  event ready from the downstream consumer.
- cnt_clr_in  in  1  synchronous clear of both counters.
- par_err_cnt_out  out  CNT_BITS  packets dropped for bad parity.
- type_drop_cnt_out  out  CNT_BITS  packets dropped for being non-multicast.

## Operation
Header fields:
- bit 0: parity.
- bit 1: payload flag.
- bits [7:6]: packet type; 2'b00 means multicast (MC).
- bits [5:2]: ignored.

Packet validity:
- Parity is odd over all 72 bits. A packet is good when the XOR of all 72 bits is 1.
- A packet is "accepted" when pkt_vld_in && pkt_rdy_out.
- Accepted packet with bad parity: dropped, par_err_cnt +1. The type is not checked.
- Accepted packet with good parity and type ≠ 00: dropped, type_drop_cnt +1.
- Accepted packet that is good and MC: key goes to evt_data_out; payload and flag are stored internally.

State machine (registered state; reset value EMPTY):
- EMPTY
  - evt_vld_out = 0.
  - Good MC accepted → load key, evt_vld_out = 1, go KEY.
  - Dropped packet → stay EMPTY.
- KEY
  - evt_vld_out = 1, evt_data_out = key.
  - evt_rdy_in with payload flag set → load stored payload, go PLD.
  - evt_rdy_in with flag clear → behave as EMPTY in the same cycle:
    - new good MC accepted → load its key, stay KEY;
    - dropped packet, or no packet offered → evt_vld_out = 0, go EMPTY.
  - No evt_rdy_in → hold.
- PLD
  - evt_vld_out = 1, evt_data_out = payload.
  - evt_rdy_in → behave as EMPTY in the same cycle (same as KEY with flag clear).
  - No evt_rdy_in → hold.

Ready rule:
- pkt_rdy_out = (state == EMPTY) | (state == KEY & !pld_flag & evt_rdy_in) | (state == PLD & evt_rdy_in).

Counters:
- Saturate at all-ones and do not wrap.
- cnt_clr_in forces both counters to 0 and takes priority over a simultaneous increment; that increment is lost.
- At most one increment per cycle, since at most one packet is accepted per cycle.

## Timing
Reset values:
- evt_vld_out = 0, evt_data_out = 0, both counters = 0, state = EMPTY.
- pkt_rdy_out = 1 once reset is released.
- Reset asserted mid-packet (KEY or PLD) discards the held key and payload. No event is emitted after release.

Latency and throughput:
- Latency is one cycle: a packet accepted at edge N gives evt_vld_out = 1 with its key after edge N.
- Throughput without payload: one MC packet per cycle, back-to-back, while evt_rdy_in stays high.
- Throughput with payload: one packet per two cycles.

Handshake stability:
- evt_data_out and evt_vld_out hold stable while evt_vld_out && !evt_rdy_in.
- evt_vld_out never drops without a handshake, except on reset.
- pkt_rdy_out depends combinationally on evt_rdy_in and state only, never on pkt_vld_in.

Other rules:
- evt_data_out is don't-care when evt_vld_out = 0, but it updates only on a load.
- A dropped packet never produces an event and never stalls pkt_rdy_out in EMPTY.

## Test plan
- **Single MC packet, no payload.** Key 0x1234_5678, payload flag 0, correct parity → one cycle later evt_data_out = 0x1234_5678 with evt_vld_out = 1. One event only; counters stay 0.
- **MC packet with payload.** Key 0xDEAD_0001, payload 0xCAFE_F00D, flag 1, evt_rdy_in held high → events 0xDEAD_0001 then 0xCAFE_F00D on consecutive cycles. pkt_rdy_out = 0 during the KEY cycle.
- **Parity error and non-MC drop.** Key 0x0000_00FF with the parity bit flipped → no event, par_err_cnt_out = 1. Then a type-01 packet with good parity → no event, type_drop_cnt_out = 1.
- **Backpressure.** evt_rdy_in low for 5 cycles with key 0xA5A5_A5A5 presented → evt_data_out is stable and pkt_rdy_out = 0 for all 5 cycles. The event is released on the cycle evt_rdy_in rises.
- **Back-to-back throughput.** 8 MC packets without payload, keys 0..7, pkt_vld_in and evt_rdy_in held high → 8 events in 8 consecutive cycles, in order. Mix in one bad-parity packet → it is skipped and the counter reads 1.
- **Counter saturation, clear, and reset.**
  - With CNT_BITS = 4, send 20 bad-parity packets → par_err_cnt_out = 15.
  - Assert cnt_clr_in together with one more bad packet → counter = 0.
  - Assert reset while in PLD → evt_vld_out = 0 immediately, and no payload appears after release.

Source files
------------

// File: rtl/pkt_disassembler.sv
// Receive-side packet disassembler: checks odd parity on 72-bit SpiNNaker packets,
// drops non-multicast ones, and emits key (then optional payload) as 32-bit events.
module pkt_disassembler #(
    parameter int PACKET_BITS = 72,
    parameter int CNT_BITS    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PACKET_BITS-1:0] pkt_data_in,
    input  logic                   pkt_vld_in,
    output logic                   pkt_rdy_out,
    output logic [31:0]            evt_data_out,
    output logic                   evt_vld_out,
    input  logic                   evt_rdy_in,
    input  logic                   cnt_clr_in,
    output logic [CNT_BITS-1:0]    par_err_cnt_out,
    output logic [CNT_BITS-1:0]    type_drop_cnt_out
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_KEY   = 2'd1,
        ST_PLD   = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] evt_data_q;
    logic        evt_vld_q;
    logic [31:0] pld_q;
    logic        pld_flag_q;

    logic        accept;
    logic        par_ok;
    logic        is_mc;
    logic        good_mc;
    logic [31:0] pkt_key;
    logic [31:0] pkt_pld;
    logic [1:0]  cnt_inc;

    assign pkt_key = pkt_data_in[39:8];
    assign pkt_pld = pkt_data_in[71:40];
    assign par_ok  = ^pkt_data_in;
    assign is_mc   = (pkt_data_in[7:6] == 2'b00);

    // The output slot is free when empty or when the event being held leaves this
    // cycle without a payload following it.
    assign pkt_rdy_out = (state_q == ST_EMPTY)
                       | ((state_q == ST_KEY) & !pld_flag_q & evt_rdy_in)
                       | ((state_q == ST_PLD) & evt_rdy_in);

    assign accept  = pkt_vld_in & pkt_rdy_out;
    assign good_mc = accept & par_ok & is_mc;

    assign cnt_inc[0] = accept & !par_ok;
    assign cnt_inc[1] = accept & par_ok & !is_mc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            evt_data_q <= 32'd0;
            evt_vld_q  <= 1'b0;
            pld_q      <= 32'd0;
            pld_flag_q <= 1'b0;
        end else begin
            if (pkt_rdy_out) begin
                if (good_mc) begin
                    evt_data_q <= pkt_key;
                    evt_vld_q  <= 1'b1;
                    pld_q      <= pkt_pld;
                    pld_flag_q <= pkt_data_in[1];
                    state_q    <= ST_KEY;
                end else begin
                    evt_vld_q  <= 1'b0;
                    state_q    <= ST_EMPTY;
                end
            end else if ((state_q == ST_KEY) && evt_rdy_in && pld_flag_q) begin
                evt_data_q <= pld_q;
                state_q    <= ST_PLD;
            end
        end
    end

    assign evt_data_out = evt_data_q;
    assign evt_vld_out  = evt_vld_q;

    // Index 0 counts parity drops, index 1 counts non-multicast drops.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_BITS-1:0] cnt_q;
            logic [CNT_BITS-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (cnt_clr_in) begin
                    cnt_d = '0;
                end else if (cnt_inc[gi] && (cnt_q != {CNT_BITS{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign par_err_cnt_out   = g_cnt[0].cnt_q;
    assign type_drop_cnt_out = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_pkt_disassembler.sv
// Scoreboard bench for pkt_disassembler: expected event words are queued as packets
// are accepted and compared as events complete their handshake.
module tb_pkt_disassembler;

    localparam int PB = 72;
    localparam int CB = 4;

    logic          clk;
    logic          reset;
    logic [PB-1:0] pkt_data_in;
    logic          pkt_vld_in;
    logic          pkt_rdy_out;
    logic [31:0]   evt_data_out;
    logic          evt_vld_out;
    logic          evt_rdy_in;
    logic          cnt_clr_in;
    logic [CB-1:0] par_err_cnt_out;
    logic [CB-1:0] type_drop_cnt_out;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];
    int exp_par = 0;
    int exp_type = 0;
    bit mon_en = 1'b1;
    int waits;

    pkt_disassembler #(.PACKET_BITS(PB), .CNT_BITS(CB)) dut (
        .clk               (clk),
        .reset             (reset),
        .pkt_data_in       (pkt_data_in),
        .pkt_vld_in        (pkt_vld_in),
        .pkt_rdy_out       (pkt_rdy_out),
        .evt_data_out      (evt_data_out),
        .evt_vld_out       (evt_vld_out),
        .evt_rdy_in        (evt_rdy_in),
        .cnt_clr_in        (cnt_clr_in),
        .par_err_cnt_out   (par_err_cnt_out),
        .type_drop_cnt_out (type_drop_cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok %s: 0x%08h", tag, got);
        end
    endtask

    function automatic logic [PB-1:0] mk_pkt(input logic [31:0] key, input logic [31:0] pld,
                                             input logic flag, input logic [1:0] ptype,
                                             input logic bad);
        logic [PB-1:0] p;
        p = {pld, key, ptype, 4'b0000, flag, 1'b0};
        p[0] = ~(^p) ^ bad;
        return p;
    endfunction

    // Present one packet and wait for it to be taken; leaves pkt_vld_in high.
    task automatic send(input logic [31:0] key, input logic [31:0] pld, input logic flag,
                        input logic [1:0] ptype, input logic bad, output int nwait);
        bit acc;
        acc = 1'b0;
        nwait = 0;
        pkt_data_in = mk_pkt(key, pld, flag, ptype, bad);
        pkt_vld_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (pkt_rdy_out) begin
                acc = 1'b1;
                break;
            end
            nwait++;
        end
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            if (cnt_clr_in) begin
                exp_par = 0;
                exp_type = 0;
            end else if (bad) begin
                if (exp_par < (1 << CB) - 1) exp_par++;
            end else if (ptype != 2'b00) begin
                if (exp_type < (1 << CB) - 1) exp_type++;
            end else begin
                exp_q.push_back(key);
                if (flag) exp_q.push_back(pld);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pkt_vld_in = 1'b0;
        pkt_data_in = '0;
    endtask

    // Events complete at the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (mon_en && evt_vld_out && evt_rdy_in) begin
            if (exp_q.size() == 0) begin
                check("unexpected_evt", evt_data_out, 32'hxxxx_xxxx);
            end else begin
                check("evt", evt_data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        pkt_data_in = '0;
        pkt_vld_in = 1'b0;
        evt_rdy_in = 1'b1;
        cnt_clr_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_vld", {31'd0, evt_vld_out}, 32'd0);
        check("rst_data", evt_data_out, 32'd0);
        check("rst_par", {28'd0, par_err_cnt_out}, 32'd0);
        check("rst_type", {28'd0, type_drop_cnt_out}, 32'd0);
        check("rst_rdy", {31'd0, pkt_rdy_out}, 32'd1);
        @(posedge clk);
        #1;

        // Single MC, no payload: one-cycle latency
        send(32'h1234_5678, 32'h0, 1'b0, 2'b00, 1'b0, waits);
        check("lat_vld", {31'd0, evt_vld_out}, 32'd1);
        check("lat_data", evt_data_out, 32'h1234_5678);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("single_drained", exp_q.size(), 32'd0);
        check("single_par", {28'd0, par_err_cnt_out}, 32'd0);
        check("single_type", {28'd0, type_drop_cnt_out}, 32'd0);

        // MC with payload: key then payload; input stalled during KEY
        send(32'hDEAD_0001, 32'hCAFE_F00D, 1'b1, 2'b00, 1'b0, waits);
        idle();
        @(negedge clk);
        check("pld_rdy_key", {31'd0, pkt_rdy_out}, 32'd0);
        @(negedge clk);
        check("pld_vld", {31'd0, evt_vld_out}, 32'd1);
        check("pld_data", evt_data_out, 32'hCAFE_F00D);
        repeat (2) @(posedge clk);
        #1;

        // Parity error and non-MC drops
        send(32'h0000_00FF, 32'h0, 1'b0, 2'b00, 1'b1, waits);
        send(32'h0000_0042, 32'h0, 1'b0, 2'b01, 1'b0, waits);
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("drop_par", {28'd0, par_err_cnt_out}, 32'd1);
        check("drop_type", {28'd0, type_drop_cnt_out}, 32'd1);
        check("drop_no_evt", exp_q.size(), 32'd0);

        // Backpressure: 5 stalled cycles
        evt_rdy_in = 1'b0;
        send(32'hA5A5_A5A5, 32'h0, 1'b0, 2'b00, 1'b0, waits);
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_data", evt_data_out, 32'hA5A5_A5A5);
            check("bp_vld", {31'd0, evt_vld_out}, 32'd1);
            check("bp_rdy", {31'd0, pkt_rdy_out}, 32'd0);
        end
        @(posedge clk);
        #1;
        evt_rdy_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("bp_drained", exp_q.size(), 32'd0);

        // Back-to-back with a bad-parity packet mixed in
        cnt_clr_in = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr_in = 1'b0;
        exp_par = 0;
        exp_type = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) send(32'hBAD0_0000, 32'h0, 1'b0, 2'b00, 1'b1, waits);
            else send(32'(i < 4 ? i : i - 1), 32'h0, 1'b0, 2'b00, 1'b0, waits);
            check("b2b_nowait", waits, 32'd0);
        end
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("b2b_par", {28'd0, par_err_cnt_out}, 32'd1);
        check("b2b_drained", exp_q.size(), 32'd0);

        // Saturation and clear
        for (int i = 0; i < 20; i++) send(32'h0000_1000 + i, 32'h0, 1'b0, 2'b00, 1'b1, waits);
        idle();
        @(negedge clk);
        check("sat_par", {28'd0, par_err_cnt_out}, 32'h0000_000F);
        check("sat_model", {28'd0, par_err_cnt_out}, 32'(exp_par));
        @(posedge clk);
        #1;
        cnt_clr_in = 1'b1;
        send(32'h0000_2000, 32'h0, 1'b0, 2'b00, 1'b1, waits);
        cnt_clr_in = 1'b0;
        idle();
        @(negedge clk);
        check("clr_par", {28'd0, par_err_cnt_out}, 32'd0);
        check("clr_type", {28'd0, type_drop_cnt_out}, 32'd0);

        // Reset while holding the payload
        @(posedge clk);
        #1;
        send(32'h7777_0001, 32'h8888_0002, 1'b1, 2'b00, 1'b0, waits);
        idle();
        @(posedge clk);
        #1;
        evt_rdy_in = 1'b0;
        @(negedge clk);
        check("pre_rst_data", evt_data_out, 32'h8888_0002);
        mon_en = 1'b0;
        exp_q.delete();
        reset = 1'b1;
        #1;
        check("rst_pld_vld", {31'd0, evt_vld_out}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        evt_rdy_in = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_vld", {31'd0, evt_vld_out}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
